rf_wr_arb: RTL and testbench

Write-port arbiter for the 32×32 register file. Several writeback sources (ALU, load unit, multi-cycle mul/div) share the file's single write port. The block gives each requester a one-entry skid buffer and arbitrates the buffered writes round-robin. It drives the file's write enable, address and data from registered outputs. Writes to r0 are accepted and silently dropped, so the port is never spent on them.

---
 rtl/rf_wr_arb_pkg.sv | 13 +
 rtl/rf_wr_arb_if.sv | 48 ++++
 rtl/rf_wr_arb_rr_arbiter.sv | 31 +++
 rtl/rf_wr_arb.sv | 90 +++++++++
 tb/tb_rf_wr_arb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wr_arb_pkg.sv
// Shared constants and the skid-buffer entry type for the register-file write-port arbiter.
package rf_wr_arb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/rf_wr_arb_if.sv
// Writeback request bus and register-file write port for rf_wr_arb.
// RF_WR_ARB_FWD_EN adds the read-port forwarding signals.
interface rf_wr_arb_if
  import rf_wr_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               RFWr;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD;
  logic [NREQ-1:0]    pend;

`ifdef RF_WR_ARB_FWD_EN
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [DW-1:0] RD1_rf;
  logic [DW-1:0] RD2_rf;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;

  modport slave (
    input  req_valid, req_addr, req_data, hold, A1, A2, RD1_rf, RD2_rf,
    output req_ready, RFWr, A3, WD, pend, RD1, RD2
  );
  modport master (
    output req_valid, req_addr, req_data, hold, A1, A2, RD1_rf, RD2_rf,
    input  req_ready, RFWr, A3, WD, pend, RD1, RD2
  );
`else
  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, RFWr, A3, WD, pend
  );
  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, RFWr, A3, WD, pend
  );
`endif

endinterface

// File: rtl/rf_wr_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr_i.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   ptr_nxt_o
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    int   idx;
    logic found;
    gnt_o     = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_nxt_o  = PW'((idx + 1) % NREQ);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: per-requester one-entry skid buffers, round-robin grant,
// registered RFWr/A3/WD. Define RF_WR_ARB_FWD_EN to forward the registered write to read ports.
module rf_wr_arb
  import rf_wr_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic         clk,
  input  logic         rst,
  rf_wr_arb_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] load;
  logic [PW-1:0]   ptr_q, ptr_d;
  rf_entry_t       ent_q [NREQ];
  rf_entry_t       sel;
  logic            rfwr_q;
  logic [AW-1:0]   a3_q;
  logic [DW-1:0]   wd_q;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i    (pend_q),
    .en_i     (~bus.hold),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .ptr_nxt_o(ptr_d)
  );

  // A granted buffer drains at the same edge it refills; r0 writes complete without buffering.
  always_comb begin
    ready  = '0;
    load   = '0;
    pend_d = pend_q;
    sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i]  = ~pend_q[i] | gnt[i];
      load[i]   = bus.req_valid[i] & ready[i] &
                  (bus.req_addr[i*AW +: AW] != RF_ZERO_ADDR);
      pend_d[i] = load[i] | (pend_q[i] & ~gnt[i]);
      if (gnt[i]) sel = ent_q[i];
    end
  end

  // NOTE: clocked state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      ptr_q  <= '0;
      rfwr_q <= 1'b0;
      a3_q   <= '0;
      wd_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      rfwr_q <= |gnt;
      if (|gnt) begin
        a3_q <= sel.addr;
        wd_q <= sel.data;
      end
    end
  end

  // NOTE: entry storage has no reset; it is only read while its pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (load[i]) begin
        ent_q[i] <= '{addr: bus.req_addr[i*AW +: AW], data: bus.req_data[i*DW +: DW]};
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.pend      = pend_q;
  assign bus.RFWr      = rfwr_q;
  assign bus.A3        = a3_q;
  assign bus.WD        = wd_q;

`ifdef RF_WR_ARB_FWD_EN
  assign bus.RD1 = (rfwr_q && (a3_q == bus.A1) && (bus.A1 != RF_ZERO_ADDR)) ? wd_q : bus.RD1_rf;
  assign bus.RD2 = (rfwr_q && (a3_q == bus.A2) && (bus.A2 != RF_ZERO_ADDR)) ? wd_q : bus.RD2_rf;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed and randomized bench for rf_wr_arb against a per-requester slot/pointer model.
module tb_rf_wr_arb;
  import rf_wr_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wr_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: each requester owns at most one waiting write; grants rotate from m_ptr.
  bit            m_full [NREQ];
  rf_entry_t     m_ent  [NREQ];
  int            m_ptr;
  logic          m_rfwr;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;

  // Requester drivers: an item stays presented until it is accepted.
  logic [NREQ-1:0] d_v;
  logic [AW-1:0]   d_a [NREQ];
  logic [DW-1:0]   d_d [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_full[i] = 1'b0;
    m_ptr  = 0;
    m_rfwr = 1'b0;
    m_a3   = '0;
    m_wd   = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    d_v[i] = 1'b1;
    d_a[i] = a;
    d_d[i] = d;
  endtask

  task automatic drive_bus(input logic h);
    bus.req_valid = d_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW] = d_a[i];
      bus.req_data[i*DW +: DW] = d_d[i];
    end
    bus.hold = h;
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic step(input logic h);
    int              w;
    logic [NREQ-1:0] exp_rdy, exp_pend, acc;
    drive_bus(h);
    #1;
    w = -1;
    if (!h) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (w < 0 && m_full[j]) w = j;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      exp_pend[i] = m_full[i];
      exp_rdy[i]  = !m_full[i] || (w == i);
    end
    check("pend", bus.pend, exp_pend);
    check("req_ready", bus.req_ready, exp_rdy);
    acc = d_v & exp_rdy;
    if (w >= 0) begin
      m_rfwr    = 1'b1;
      m_a3      = m_ent[w].addr;
      m_wd      = m_ent[w].data;
      m_full[w] = 1'b0;
      m_ptr     = (w + 1) % NREQ;
    end else begin
      m_rfwr = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && d_a[i] != 0) begin
        m_full[i]     = 1'b1;
        m_ent[i].addr = d_a[i];
        m_ent[i].data = d_d[i];
      end
    end
    d_v = d_v & ~acc;
    @(negedge clk);
    check("RFWr", bus.RFWr, m_rfwr);
    check("A3", bus.A3, m_a3);
    check("WD", bus.WD, m_wd);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    d_v = '0;
    drive_bus(1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_RFWr", bus.RFWr, 1'b0);
    check("rst_A3", bus.A3, '0);
    check("rst_WD", bus.WD, '0);
    check("rst_pend", bus.pend, '0);
    check("rst_ready", bus.req_ready, {NREQ{1'b1}});
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    d_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      d_a[i] = '0;
      d_d[i] = '0;
    end
    drive_bus(1'b0);
`ifdef RF_WR_ARB_FWD_EN
    bus.A1 = '0; bus.A2 = '0; bus.RD1_rf = '0; bus.RD2_rf = '0;
`endif
    model_reset();

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("init_RFWr", bus.RFWr, 1'b0);
    check("init_A3", bus.A3, '0);
    check("init_WD", bus.WD, '0);
    check("init_pend", bus.pend, '0);
    check("init_ready", bus.req_ready, 3'b111);
    @(negedge clk);
    rst = 1'b1;

    // Single write from req0: file write enable exactly two edges after acceptance
    set_req(0, 5'd5, 32'hDEADBEEF);
    step(1'b0);
    check("t1_pend", bus.pend, 3'b001);
    check("t1_idle", bus.RFWr, 1'b0);
    step(1'b0);
    check("t1_RFWr", bus.RFWr, 1'b1);
    check("t1_A3", bus.A3, 5'd5);
    check("t1_WD", bus.WD, 32'hDEADBEEF);
`ifdef RF_WR_ARB_FWD_EN
    bus.A1 = 5'd5; bus.RD1_rf = 32'h0;
    bus.A2 = 5'd0; bus.RD2_rf = 32'h0000_0ABC;
    #1;
    check("fwd_RD1", bus.RD1, 32'hDEADBEEF);
    check("fwd_RD2_r0", bus.RD2, 32'h0000_0ABC);
    bus.A1 = '0; bus.A2 = '0; bus.RD1_rf = '0; bus.RD2_rf = '0;
`endif
    step(1'b0);
    check("t1_done", bus.RFWr, 1'b0);

    // All three requesters at once from ptr=0: writes to 1, 2, 3 on consecutive cycles
    do_reset();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    step(1'b0);
    check("t2_pend", bus.pend, 3'b111);
    step(1'b0);
    check("t2_w0", bus.A3, 5'd1);
    step(1'b0);
    check("t2_w1", bus.A3, 5'd2);
    check("t2_d1", bus.WD, 32'h22);
    step(1'b0);
    check("t2_w2", bus.A3, 5'd3);
    step(1'b0);
    check("t2_done", bus.RFWr, 1'b0);

    // Write to r0 completes its handshake but never reaches the file
    set_req(1, 5'd0, 32'hFFFFFFFF);
    step(1'b0);
    check("t3_accepted", d_v[1], 1'b0);
    check("t3_pend", bus.pend, 3'b000);
    step(1'b0);
    check("t3_no_write", bus.RFWr, 1'b0);

    // hold for 4 cycles while req0 streams, then release
    set_req(0, 5'd8, 32'h80);
    step(1'b1);
    set_req(0, 5'd9, 32'h90);
    for (int c = 0; c < 3; c++) begin
      step(1'b1);
      check("t4_held_RFWr", bus.RFWr, 1'b0);
      check("t4_held_pend", bus.pend[0], 1'b1);
      check("t4_stalled", d_v[0], 1'b1);
    end
    step(1'b0);
    check("t4_rel_A3", bus.A3, 5'd8);
    check("t4_rel_RFWr", bus.RFWr, 1'b1);
    set_req(0, 5'd10, 32'hA0);
    step(1'b0);
    check("t4_s1", bus.A3, 5'd9);
    set_req(0, 5'd11, 32'hB0);
    step(1'b0);
    check("t4_s2", bus.A3, 5'd10);
    step(1'b0);
    check("t4_s3", bus.A3, 5'd11);
    step(1'b0);

    // Reset mid-operation with every buffer full and a write in the output register
    set_req(0, 5'd4, 32'h44);
    set_req(1, 5'd5, 32'h55);
    set_req(2, 5'd6, 32'h66);
    step(1'b0);
    set_req(0, 5'd12, 32'hC0);
    set_req(1, 5'd13, 32'hD0);
    set_req(2, 5'd14, 32'hE0);
    step(1'b0);
    check("t5_pend_full", bus.pend, 3'b111);
    check("t5_RFWr", bus.RFWr, 1'b1);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      check("t5_no_write", bus.RFWr, 1'b0);
    end

    // Randomized traffic with hold, r0 writes and occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!d_v[i] && $urandom_range(0, 9) < 6) begin
          d_v[i] = 1'b1;
          d_a[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
          d_d[i] = $urandom;
        end
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 9) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
